// File: rtl/tbps_crc_checker.sv
// Receive-side CRC checker: buffers each packet until the engine's CRC verdict
// arrives, then releases it on a ready/valid stream with a per-packet error flag.

module tbps_crc_checker_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             reserve_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] ALMOST_CNT = FULL_CNT - 1'b1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d, count;

    // reserve_i counts one storage slot held outside the FIFO
    always_comb begin
        wptr_d  = wptr_q + {{AW{1'b0}}, push_i};
        rptr_d  = rptr_q + {{AW{1'b0}}, pop_i};
        count   = wptr_q - rptr_q;
        empty_o = (wptr_q == rptr_q);
        full_o  = (count == FULL_CNT) || (reserve_i && (count == ALMOST_CNT));
        rdata_o = mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end
endmodule

module tbps_crc_checker #(
    parameter int DWIDTH     = 512,
    parameter int CRC_WIDTH  = 32,
    parameter int DATA_DEPTH = 64,
    parameter int PKT_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DWIDTH-1:0]     in_data,
    input  logic [DWIDTH/8-1:0]   in_byteEn,
    input  logic                  in_dlast,
    input  logic                  in_flitEn,
    input  logic [CRC_WIDTH-1:0]  in_fcs,
    input  logic [CRC_WIDTH-1:0]  crc_in,
    input  logic                  crc_in_vld,
    output logic [DWIDTH-1:0]     out_data,
    output logic [DWIDTH/8-1:0]   out_byteEn,
    output logic                  out_dlast,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_crc_err,
    output logic                  overflow,
    output logic                  proto_err,
    output logic [31:0]           pkt_cnt,
    output logic [31:0]           err_cnt
);
    localparam int BW = DWIDTH / 8;
    localparam int EW = DWIDTH + BW + 1;

    logic [EW-1:0]        dataHead;
    logic                 dataEmpty, dataFull, dataPush, dataPop, headLast;
    logic [CRC_WIDTH-1:0] fcsHead;
    logic                 fcsEmpty, fcsFull, fcsPush, fcsPop;
    logic                 verdHead, verdEmpty, verdFull, verdPush, verdPop, verdErr;
    logic                 outFire;

    logic                 outValid_q, outValid_d;
    logic [DWIDTH-1:0]    outData_q, outData_d;
    logic [BW-1:0]        outByteEn_q, outByteEn_d;
    logic                 outLast_q, outLast_d;
    logic                 outErr_q, outErr_d;
    logic                 overflow_q, overflow_d;
    logic                 protoErr_q, protoErr_d;
    logic [31:0]          pktCnt_q, pktCnt_d;
    logic [31:0]          errCnt_q, errCnt_d;

    // The output register counts against data capacity, so total beats held never exceed DATA_DEPTH
    tbps_crc_checker_fifo #(.WIDTH(EW), .DEPTH(DATA_DEPTH)) u_dataFifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (dataPush),
        .pop_i     (dataPop),
        .reserve_i (outValid_q),
        .wdata_i   ({in_data, in_byteEn, in_dlast}),
        .rdata_o   (dataHead),
        .empty_o   (dataEmpty),
        .full_o    (dataFull)
    );

    tbps_crc_checker_fifo #(.WIDTH(CRC_WIDTH), .DEPTH(PKT_DEPTH)) u_fcsFifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (fcsPush),
        .pop_i     (fcsPop),
        .reserve_i (1'b0),
        .wdata_i   (in_fcs),
        .rdata_o   (fcsHead),
        .empty_o   (fcsEmpty),
        .full_o    (fcsFull)
    );

    tbps_crc_checker_fifo #(.WIDTH(1), .DEPTH(PKT_DEPTH)) u_verdFifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (verdPush),
        .pop_i     (verdPop),
        .reserve_i (1'b0),
        .wdata_i   (verdErr),
        .rdata_o   (verdHead),
        .empty_o   (verdEmpty),
        .full_o    (verdFull)
    );

    always_comb begin
        outFire  = outValid_q & out_ready;
        headLast = dataHead[0];
        dataPop  = (!outValid_q || out_ready) && !dataEmpty && (!headLast || !verdEmpty);
        dataPush = in_flitEn && (!dataFull || outFire);
        fcsPop   = crc_in_vld && !fcsEmpty;
        fcsPush  = dataPush && in_dlast && (!fcsFull || fcsPop);
        verdPop  = dataPop && headLast;
        verdPush = crc_in_vld && (!verdFull || verdPop);
        verdErr  = fcsEmpty || (crc_in != fcsHead);

        outValid_d  = outValid_q;
        outData_d   = outData_q;
        outByteEn_d = outByteEn_q;
        outLast_d   = outLast_q;
        outErr_d    = outErr_q;
        if (dataPop) begin
            outValid_d  = 1'b1;
            outData_d   = dataHead[EW-1 -: DWIDTH];
            outByteEn_d = dataHead[BW:1];
            outLast_d   = headLast;
            outErr_d    = headLast & verdHead;
        end else if (outFire) begin
            outValid_d = 1'b0;
        end

        overflow_d = overflow_q || (in_flitEn && !dataPush);
        protoErr_d = protoErr_q || (crc_in_vld && fcsEmpty)
                   || (dataPush && in_dlast && !fcsPush) || (crc_in_vld && !verdPush);
        pktCnt_d   = pktCnt_q + {31'd0, outFire & outLast_q};
        errCnt_d   = errCnt_q + {31'd0, outFire & outLast_q & outErr_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q  <= 1'b0;
            outData_q   <= '0;
            outByteEn_q <= '0;
            outLast_q   <= 1'b0;
            outErr_q    <= 1'b0;
            overflow_q  <= 1'b0;
            protoErr_q  <= 1'b0;
            pktCnt_q    <= '0;
            errCnt_q    <= '0;
        end else begin
            outValid_q  <= outValid_d;
            outData_q   <= outData_d;
            outByteEn_q <= outByteEn_d;
            outLast_q   <= outLast_d;
            outErr_q    <= outErr_d;
            overflow_q  <= overflow_d;
            protoErr_q  <= protoErr_d;
            pktCnt_q    <= pktCnt_d;
            errCnt_q    <= errCnt_d;
        end
    end

    assign out_valid   = outValid_q;
    assign out_data    = outData_q;
    assign out_byteEn  = outByteEn_q;
    assign out_dlast   = outLast_q;
    assign out_crc_err = outErr_q;
    assign overflow    = overflow_q;
    assign proto_err   = protoErr_q;
    assign pkt_cnt     = pktCnt_q;
    assign err_cnt     = errCnt_q;
endmodule

// File: tb/tb_tbps_crc_checker.sv
// Bench for tbps_crc_checker: plays the CRC engine with a byte-wise CRC-32 model
// and scoreboards every released beat against a queue of expected packets.

module tb_tbps_crc_checker;
    localparam int DW = 64;
    localparam int BW = 8;
    localparam int CW = 32;
    localparam int DD = 8;
    localparam int PD = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [BW-1:0] be;
        logic          last;
        logic          err;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic [BW-1:0] in_byteEn;
    logic          in_dlast, in_flitEn;
    logic [CW-1:0] in_fcs, crc_in;
    logic          crc_in_vld;
    logic [DW-1:0] out_data;
    logic [BW-1:0] out_byteEn;
    logic          out_dlast, out_valid, out_ready, out_crc_err, overflow, proto_err;
    logic [31:0]   pkt_cnt, err_cnt;

    int            checks = 0;
    int            errors = 0;
    beat_t         expQ[$];
    logic [CW-1:0] pendingCrc[$];
    logic [7:0]    pkt[$];
    int            modelPkts = 0;
    int            modelErrs = 0;
    int            beatsSeen = 0;
    bit            checkEn = 1'b1;
    bit            randReady = 1'b0;
    bit            prevHeld = 1'b0;
    beat_t         held;

    tbps_crc_checker #(.DWIDTH(DW), .CRC_WIDTH(CW), .DATA_DEPTH(DD), .PKT_DEPTH(PD)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_byteEn(in_byteEn),
        .in_dlast(in_dlast), .in_flitEn(in_flitEn), .in_fcs(in_fcs),
        .crc_in(crc_in), .crc_in_vld(crc_in_vld), .out_data(out_data),
        .out_byteEn(out_byteEn), .out_dlast(out_dlast), .out_valid(out_valid),
        .out_ready(out_ready), .out_crc_err(out_crc_err), .overflow(overflow),
        .proto_err(proto_err), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reflected CRC-32 (poly 04C11DB7, init/xorout FFFFFFFF) over the packet bytes
    function automatic logic [31:0] crc32(input logic [7:0] q[$]);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            c = c ^ {24'd0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: sample at the falling edge, return 1ns after the rising edge
    task automatic tick();
        beat_t e;
        @(negedge clk);
        if (checkEn) begin
            if (prevHeld) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_data", out_data, held.data);
                checkOutput("hold_byteEn", out_byteEn, held.be);
                checkOutput("hold_dlast", out_dlast, held.last);
                checkOutput("hold_err", out_crc_err, held.err);
            end
            if (out_valid === 1'b1 && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("extra_beat", out_valid, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("out_data", out_data, e.data);
                    checkOutput("out_byteEn", out_byteEn, e.be);
                    checkOutput("out_dlast", out_dlast, e.last);
                    checkOutput("out_crc_err", out_crc_err, e.err);
                end
            end
        end
        if (out_valid === 1'b1 && out_ready) beatsSeen++;
        prevHeld  = (out_valid === 1'b1) && !out_ready;
        held.data = out_data;
        held.be   = out_byteEn;
        held.last = out_dlast;
        held.err  = out_crc_err;
        @(posedge clk);
        #1;
        if (randReady) out_ready = ($urandom_range(3, 0) != 0);
    endtask

    task automatic applyStimulus(input logic [7:0] q[$], input logic [31:0] fcs);
        int          nb = (q.size() + 7) / 8;
        logic [31:0] crc = crc32(q);
        logic        err = (crc != fcs);
        for (int b = 0; b < nb; b++) begin
            beat_t e;
            logic [DW-1:0] d = '0;
            logic [BW-1:0] be = '0;
            for (int k = 0; k < 8; k++) begin
                if (b * 8 + k < q.size()) begin
                    d[8*k +: 8] = q[b*8+k];
                    be[k] = 1'b1;
                end
            end
            in_data   = d;
            in_byteEn = be;
            in_dlast  = (b == nb - 1);
            in_fcs    = (b == nb - 1) ? fcs : $urandom();
            in_flitEn = 1'b1;
            e.data = d;
            e.be   = be;
            e.last = (b == nb - 1);
            e.err  = (b == nb - 1) ? err : 1'b0;
            expQ.push_back(e);
            tick();
        end
        in_flitEn = 1'b0;
        in_dlast  = 1'b0;
        pendingCrc.push_back(crc);
        modelPkts++;
        if (err) modelErrs++;
    endtask

    task automatic randomPacket(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom()));
    endtask

    task automatic sendRandom(input int maxLen);
        logic [31:0] crc;
        logic [31:0] fcs;
        randomPacket($urandom_range(maxLen, 1));
        crc = crc32(pkt);
        fcs = ($urandom_range(1, 0) == 1) ? (crc ^ (32'h1 << $urandom_range(31, 0))) : crc;
        applyStimulus(pkt, fcs);
    endtask

    task automatic deliverVerdict();
        if (pendingCrc.size() > 0) begin
            crc_in     = pendingCrc.pop_front();
            crc_in_vld = 1'b1;
            tick();
            crc_in_vld = 1'b0;
            crc_in     = $urandom();
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && expQ.size() > 0; i++) tick();
        checkOutput("drain_done", expQ.size(), 0);
    endtask

    task automatic holdReset();
        rst_n      = 1'b0;
        in_flitEn  = 1'b0;
        in_dlast   = 1'b0;
        crc_in_vld = 1'b0;
        expQ.delete();
        pendingCrc.delete();
        modelPkts = 0;
        modelErrs = 0;
        prevHeld  = 1'b0;
        #1;
    endtask

    task automatic releaseReset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, out_valid, 0);
        checkOutput({tag, "_data"}, out_data, 0);
        checkOutput({tag, "_byteEn"}, out_byteEn, 0);
        checkOutput({tag, "_dlast"}, out_dlast, 0);
        checkOutput({tag, "_crc_err"}, out_crc_err, 0);
        checkOutput({tag, "_overflow"}, overflow, 0);
        checkOutput({tag, "_proto_err"}, proto_err, 0);
        checkOutput({tag, "_pkt_cnt"}, pkt_cnt, 0);
        checkOutput({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    initial begin
        string s = "123456789";
        rst_n = 1'b0; in_data = '0; in_byteEn = '0; in_dlast = 1'b0; in_flitEn = 1'b0;
        in_fcs = '0; crc_in = '0; crc_in_vld = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        holdReset();
        checkResetState("reset");
        releaseReset();

        $display("[TB] pass case with verdict gating");
        out_ready = 1'b1;
        pkt.delete();
        for (int i = 0; i < s.len(); i++) pkt.push_back(s[i]);
        applyStimulus(pkt, 32'hCBF4_3926);
        checkOutput("latency_valid", out_valid, 1);
        checkOutput("latency_first_beat", out_dlast, 0);
        tick();
        tick();
        checkOutput("gate_hold", out_valid, 0);
        deliverVerdict();
        checkOutput("gate_edge", out_valid, 0);
        tick();
        checkOutput("gate_release_valid", out_valid, 1);
        checkOutput("gate_release_last", out_dlast, 1);
        tick();
        checkOutput("pass_pkt_cnt", pkt_cnt, modelPkts);
        checkOutput("pass_err_cnt", err_cnt, modelErrs);

        $display("[TB] mismatch case");
        applyStimulus(pkt, 32'hCBF4_3927);
        deliverVerdict();
        drain(20);
        checkOutput("mis_pkt_cnt", pkt_cnt, modelPkts);
        checkOutput("mis_err_cnt", err_cnt, modelErrs);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        for (int p = 0; p < 3; p++) sendRandom(16);
        for (int p = 0; p < 3; p++) deliverVerdict();
        repeat (20) tick();
        out_ready = 1'b1;
        drain(40);
        checkOutput("bp_overflow", overflow, 0);
        checkOutput("bp_proto_err", proto_err, 0);
        checkOutput("bp_pkt_cnt", pkt_cnt, modelPkts);
        checkOutput("bp_err_cnt", err_cnt, modelErrs);

        $display("[TB] random traffic");
        randReady = 1'b1;
        for (int k = 0; k < 12; k++) begin
            sendRandom(24);
            deliverVerdict();
            if (k % 2 == 1) drain(80);
        end
        randReady = 1'b0;
        out_ready = 1'b1;
        checkOutput("rand_pkt_cnt", pkt_cnt, modelPkts);
        checkOutput("rand_err_cnt", err_cnt, modelErrs);
        checkOutput("rand_overflow", overflow, 0);

        $display("[TB] protocol fault and mid-packet reset");
        holdReset();
        releaseReset();
        crc_in = $urandom();
        crc_in_vld = 1'b1;
        tick();
        crc_in_vld = 1'b0;
        checkOutput("proto_err_set", proto_err, 1);
        checkOutput("proto_no_valid", out_valid, 0);
        holdReset();
        releaseReset();
        out_ready = 1'b0;
        in_data = {$urandom(), $urandom()}; in_byteEn = '1; in_dlast = 1'b0; in_flitEn = 1'b1;
        tick();
        in_flitEn = 1'b0;
        tick();
        checkOutput("pre_reset_valid", out_valid, 1);
        holdReset();
        checkResetState("midpkt_reset");
        releaseReset();
        out_ready = 1'b1;
        sendRandom(16);
        deliverVerdict();
        drain(20);
        checkOutput("post_reset_pkt_cnt", pkt_cnt, modelPkts);
        checkOutput("post_reset_err_cnt", err_cnt, modelErrs);
        checkOutput("post_reset_proto_err", proto_err, 0);

        $display("[TB] overflow");
        holdReset();
        releaseReset();
        out_ready = 1'b0;
        checkEn = 1'b0;
        for (int i = 0; i < DD + 2; i++) begin
            in_data = {$urandom(), $urandom()}; in_byteEn = '1; in_dlast = 1'b0; in_flitEn = 1'b1;
            tick();
            if (i == DD - 1) checkOutput("ovf_not_yet", overflow, 0);
            if (i == DD) checkOutput("ovf_set", overflow, 1);
        end
        in_flitEn = 1'b0;
        out_ready = 1'b1;
        beatsSeen = 0;
        for (int i = 0; i < 40 && out_valid === 1'b1; i++) tick();
        checkOutput("ovf_drained_valid", out_valid, 0);
        checkOutput("ovf_beats_kept", beatsSeen, DD);
        checkOutput("ovf_sticky", overflow, 1);
        checkEn = 1'b1;
        holdReset();
        checkOutput("ovf_reset_clear", overflow, 0);
        releaseReset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
